// File: rtl/dmem_arbiter_if.sv
// Bundle of core, network, SRAM and reservation signals around the DMEM arbiter.
// The arbiter takes the slave view; the surrounding core/network/SRAM take the master view.
interface dmem_arbiter_if #(
    parameter int data_width_p = 32,
    parameter int dmem_size_p  = 1024
);
    localparam int dmem_addr_width_lp = (dmem_size_p <= 1) ? 1 : $clog2(dmem_size_p);
    localparam int mask_width_lp      = data_width_p >> 3;

    logic                          core_v_i;
    logic                          core_w_i;
    logic                          core_reserve_i;
    logic [dmem_addr_width_lp-1:0] core_addr_i;
    logic [data_width_p-1:0]       core_data_i;
    logic [mask_width_lp-1:0]      core_mask_i;
    logic                          core_yumi_o;
    logic                          core_data_v_o;
    logic [data_width_p-1:0]       core_data_o;

    logic                          net_v_i;
    logic                          net_w_i;
    logic [dmem_addr_width_lp-1:0] net_addr_i;
    logic [data_width_p-1:0]       net_data_i;
    logic [mask_width_lp-1:0]      net_mask_i;
    logic                          net_yumi_o;
    logic                          net_resp_v_o;
    logic [data_width_p-1:0]       net_data_o;

    logic                          mem_v_o;
    logic                          mem_w_o;
    logic [dmem_addr_width_lp-1:0] mem_addr_o;
    logic [data_width_p-1:0]       mem_data_o;
    logic [mask_width_lp-1:0]      mem_mask_o;
    logic [data_width_p-1:0]       mem_data_i;

    logic                          reserved_o;
    logic [dmem_addr_width_lp-1:0] reserved_addr_o;

    modport slave (
        input  core_v_i, core_w_i, core_reserve_i, core_addr_i, core_data_i, core_mask_i,
        output core_yumi_o, core_data_v_o, core_data_o,
        input  net_v_i, net_w_i, net_addr_i, net_data_i, net_mask_i,
        output net_yumi_o, net_resp_v_o, net_data_o,
        output mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
        input  mem_data_i,
        output reserved_o, reserved_addr_o
    );

    modport master (
        output core_v_i, core_w_i, core_reserve_i, core_addr_i, core_data_i, core_mask_i,
        input  core_yumi_o, core_data_v_o, core_data_o,
        output net_v_i, net_w_i, net_addr_i, net_data_i, net_mask_i,
        input  net_yumi_o, net_resp_v_o, net_data_o,
        input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
        output mem_data_i,
        input  reserved_o, reserved_addr_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: fixed core priority with a network starvation guard,
// 1-cycle read responses, and ownership of the core's load-reserved reservation.
module dmem_arbiter #(
    parameter int data_width_p       = 32,
    parameter int dmem_size_p        = 1024,
    parameter int net_starve_limit_p = 4,
    localparam int dmem_addr_width_lp = (dmem_size_p <= 1) ? 1 : $clog2(dmem_size_p),
    localparam int mask_width_lp      = data_width_p >> 3
) (
    input logic          clk_i,
    input logic          reset_i,
    dmem_arbiter_if.slave bus
);
    localparam int starve_width_lp = $clog2(net_starve_limit_p + 1);
    localparam logic [starve_width_lp-1:0] starve_limit_lp = starve_width_lp'(net_starve_limit_p);

    // Handshake: a requester raises v with a stable payload and holds both until it
    // sees yumi high in the same cycle; yumi is the grant and the access happens that cycle.
    // At most one of core_yumi_o / net_yumi_o is high, and never without its v.

    logic [starve_width_lp-1:0]    starve_cnt_r;
    logic                          core_rd_r;
    logic                          net_resp_r;
    logic                          reserved_r;
    logic [dmem_addr_width_lp-1:0] reserved_addr_r;

    logic net_win;
    logic core_win;

    assign net_win  = bus.net_v_i & (~bus.core_v_i | (starve_cnt_r == starve_limit_lp));
    assign core_win = bus.core_v_i & ~net_win;

    assign bus.net_yumi_o  = net_win;
    assign bus.core_yumi_o = core_win;

    always_comb begin
        bus.mem_v_o    = 1'b0;
        bus.mem_w_o    = 1'b0;
        bus.mem_addr_o = '0;
        bus.mem_data_o = '0;
        bus.mem_mask_o = '0;
        if (net_win) begin
            bus.mem_v_o    = 1'b1;
            bus.mem_w_o    = bus.net_w_i;
            bus.mem_addr_o = bus.net_addr_i;
            bus.mem_data_o = bus.net_data_i;
            bus.mem_mask_o = bus.net_mask_i;
        end else if (core_win) begin
            bus.mem_v_o    = 1'b1;
            bus.mem_w_o    = bus.core_w_i;
            bus.mem_addr_o = bus.core_addr_i;
            bus.mem_data_o = bus.core_data_i;
            bus.mem_mask_o = bus.core_mask_i;
        end
    end

    // Whichever requester won drives the SRAM, so conflict detection can use the SRAM bus.
    logic reserve_hit_write;
    assign reserve_hit_write = bus.mem_v_o & bus.mem_w_o & (|bus.mem_mask_o)
                             & (bus.mem_addr_o == reserved_addr_r);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_r    <= '0;
            core_rd_r       <= 1'b0;
            net_resp_r      <= 1'b0;
            reserved_r      <= 1'b0;
            reserved_addr_r <= '0;
        end else begin
            if (bus.net_v_i & ~net_win) starve_cnt_r <= starve_cnt_r + 1'b1;
            else                        starve_cnt_r <= '0;

            core_rd_r  <= core_win & ~bus.core_w_i;
            net_resp_r <= net_win;

            if (core_win & ~bus.core_w_i & bus.core_reserve_i) begin
                reserved_r      <= 1'b1;
                reserved_addr_r <= bus.core_addr_i;
            end else if (reserve_hit_write) begin
                reserved_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!(bus.core_reserve_i && bus.core_w_i));
    end

    assign bus.core_data_v_o   = core_rd_r;
    assign bus.core_data_o     = bus.mem_data_i;
    assign bus.net_resp_v_o    = net_resp_r;
    assign bus.net_data_o      = bus.mem_data_i;
    assign bus.reserved_o      = reserved_r;
    assign bus.reserved_addr_o = reserved_addr_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: SRAM stub, transaction-level reference model checked every
// cycle at negedge, plus directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;
    localparam int DW    = 32;
    localparam int WORDS = 1024;
    localparam int LIMIT = 4;
    localparam int AW    = 10;
    localparam int MW    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.data_width_p(DW), .dmem_size_p(WORDS)) bus ();

    dmem_arbiter #(
        .data_width_p(DW), .dmem_size_p(WORDS), .net_starve_limit_p(LIMIT)
    ) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 'h10)      return 32'hDEADBEEF;
        else if (a == 'h50) return 32'hA1B2C3D4;
        else                return 32'hC0DE0000 | DW'(a);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // SRAM stub: 1-cycle read latency, reloaded with the known image during reset.
    logic [DW-1:0] sram [0:WORDS-1];
    initial bus.mem_data_i = '0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= init_word(i);
        end
        if (bus.mem_v_o) begin
            if (bus.mem_w_o) sram[bus.mem_addr_o] <= merge(sram[bus.mem_addr_o], bus.mem_data_o, bus.mem_mask_o);
            else             bus.mem_data_i <= sram[bus.mem_addr_o];
        end
    end

    // Reference model: memory contents, how long the network has been waiting,
    // pending responses and the reservation.
    logic [DW-1:0] ref_mem [0:WORDS-1];
    logic          live = 1'b0;
    int            net_waited;
    logic          exp_core_rsp, exp_net_rsp, exp_net_rd;
    logic [DW-1:0] exp_core_data, exp_net_data;
    logic          exp_res;
    logic [AW-1:0] exp_res_addr;

    always @(negedge clk) begin
        logic          net_gets;
        logic          core_gets;
        logic [AW-1:0] g_addr;
        logic          g_w;
        logic [DW-1:0] g_data;
        logic [MW-1:0] g_mask;
        net_gets  = bus.net_v_i && (!bus.core_v_i || net_waited >= LIMIT);
        core_gets = bus.core_v_i && !net_gets;
        g_addr = net_gets ? bus.net_addr_i : bus.core_addr_i;
        g_w    = net_gets ? bus.net_w_i    : bus.core_w_i;
        g_data = net_gets ? bus.net_data_i : bus.core_data_i;
        g_mask = net_gets ? bus.net_mask_i : bus.core_mask_i;
        if (live) begin
            chk("net_yumi", 64'(bus.net_yumi_o), 64'(net_gets));
            chk("core_yumi", 64'(bus.core_yumi_o), 64'(core_gets));
            chk("mem_v", 64'(bus.mem_v_o), 64'(net_gets || core_gets));
            chk("mem_w", 64'(bus.mem_w_o), (net_gets || core_gets) ? 64'(g_w) : 64'd0);
            chk("mem_addr", 64'(bus.mem_addr_o), (net_gets || core_gets) ? 64'(g_addr) : 64'd0);
            chk("mem_data", 64'(bus.mem_data_o), (net_gets || core_gets) ? 64'(g_data) : 64'd0);
            chk("mem_mask", 64'(bus.mem_mask_o), (net_gets || core_gets) ? 64'(g_mask) : 64'd0);
            chk("core_data_v", 64'(bus.core_data_v_o), 64'(exp_core_rsp));
            if (exp_core_rsp) chk("core_data", 64'(bus.core_data_o), 64'(exp_core_data));
            chk("net_resp_v", 64'(bus.net_resp_v_o), 64'(exp_net_rsp));
            if (exp_net_rsp && exp_net_rd) chk("net_data", 64'(bus.net_data_o), 64'(exp_net_data));
            chk("reserved", 64'(bus.reserved_o), 64'(exp_res));
            chk("reserved_addr", 64'(bus.reserved_addr_o), 64'(exp_res_addr));
        end
        if (reset) begin
            live         = 1'b1;
            net_waited   = 0;
            exp_core_rsp = 1'b0;
            exp_net_rsp  = 1'b0;
            exp_net_rd   = 1'b0;
            exp_res      = 1'b0;
            exp_res_addr = '0;
            for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        end else if (live) begin
            net_waited    = (bus.net_v_i && !net_gets) ? net_waited + 1 : 0;
            exp_core_rsp  = core_gets && !bus.core_w_i;
            exp_core_data = ref_mem[bus.core_addr_i];
            exp_net_rsp   = net_gets;
            exp_net_rd    = !bus.net_w_i;
            exp_net_data  = ref_mem[bus.net_addr_i];
            if ((net_gets || core_gets) && g_w) begin
                ref_mem[g_addr] = merge(ref_mem[g_addr], g_data, g_mask);
                if (g_addr == exp_res_addr && g_mask != '0) exp_res = 1'b0;
            end
            if (core_gets && !bus.core_w_i && bus.core_reserve_i) begin
                exp_res      = 1'b1;
                exp_res_addr = bus.core_addr_i;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.core_v_i = 0; bus.core_w_i = 0; bus.core_reserve_i = 0;
        bus.core_addr_i = '0; bus.core_data_i = '0; bus.core_mask_i = '0;
        bus.net_v_i = 0; bus.net_w_i = 0;
        bus.net_addr_i = '0; bus.net_data_i = '0; bus.net_mask_i = '0;
    endtask

    task automatic core_req(input logic w, input logic rsv, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [MW-1:0] m);
        bus.core_v_i = 1; bus.core_w_i = w; bus.core_reserve_i = rsv;
        bus.core_addr_i = a; bus.core_data_i = d; bus.core_mask_i = m;
    endtask

    task automatic net_req(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        bus.net_v_i = 1; bus.net_w_i = w;
        bus.net_addr_i = a; bus.net_data_i = d; bus.net_mask_i = m;
    endtask

    initial begin
        logic cg, ng;
        idle();
        reset = 1;
        repeat (3) tick();
        reset = 0;

        @(negedge clk);
        chk("rst_core_data_v", 64'(bus.core_data_v_o), 64'd0);
        chk("rst_net_resp_v", 64'(bus.net_resp_v_o), 64'd0);
        chk("rst_reserved", 64'(bus.reserved_o), 64'd0);
        chk("rst_reserved_addr", 64'(bus.reserved_addr_o), 64'd0);
        tick();

        // Idle network read of 0x10
        net_req(0, 10'h10, '0, 4'hF);
        @(negedge clk);
        chk("t1_net_yumi", 64'(bus.net_yumi_o), 64'd1);
        tick(); idle();
        @(negedge clk);
        chk("t1_net_resp_v", 64'(bus.net_resp_v_o), 64'd1);
        chk("t1_net_data", 64'(bus.net_data_o), 64'hDEADBEEF);
        tick();

        // Starvation: core and network both held high
        core_req(0, 0, 10'h30, '0, 4'hF);
        net_req(0, 10'h10, '0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_net_yumi", 64'(bus.net_yumi_o), (i == 4) ? 64'd1 : 64'd0);
            chk("t2_core_yumi", 64'(bus.core_yumi_o), (i == 4) ? 64'd0 : 64'd1);
            if (i == 1) chk("t2_core_data", 64'(bus.core_data_o), 64'hC0DE0030);
            tick();
        end
        idle(); tick();

        // Reservation vs network writes
        core_req(0, 1, 10'h20, '0, 4'hF);
        tick(); idle();
        @(negedge clk);
        chk("t3_reserved", 64'(bus.reserved_o), 64'd1);
        chk("t3_reserved_addr", 64'(bus.reserved_addr_o), 64'h20);
        net_req(1, 10'h21, 32'hAA, 4'b0001);
        tick(); idle();
        @(negedge clk);
        chk("t3_other_addr_keeps", 64'(bus.reserved_o), 64'd1);
        net_req(1, 10'h20, 32'h55, 4'b0001);
        tick(); idle();
        @(negedge clk);
        chk("t3_net_write_clears", 64'(bus.reserved_o), 64'd0);
        tick();

        // Core write to its own reserved word
        core_req(0, 1, 10'h20, '0, 4'hF);
        tick();
        core_req(1, 0, 10'h20, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("t4_core_yumi", 64'(bus.core_yumi_o), 64'd1);
        chk("t4_reserved_before", 64'(bus.reserved_o), 64'd1);
        tick(); idle();
        @(negedge clk);
        chk("t4_reserved_cleared", 64'(bus.reserved_o), 64'd0);
        chk("t4_no_read_pulse", 64'(bus.core_data_v_o), 64'd0);
        tick();

        // Reset arriving with a granted core read and a live reservation
        core_req(0, 1, 10'h40, '0, 4'hF);
        tick();
        core_req(0, 0, 10'h30, '0, 4'hF);
        reset = 1;
        @(negedge clk);
        chk("t5_core_yumi", 64'(bus.core_yumi_o), 64'd1);
        tick(); idle();
        @(negedge clk);
        chk("t5_no_data_v", 64'(bus.core_data_v_o), 64'd0);
        chk("t5_reserved", 64'(bus.reserved_o), 64'd0);
        chk("t5_net_resp_v", 64'(bus.net_resp_v_o), 64'd0);
        tick();
        reset = 0;
        tick();

        // Network partial write then core read of the same word
        net_req(1, 10'h50, 32'h11223344, 4'b0101);
        tick(); idle();
        core_req(0, 0, 10'h50, '0, 4'hF);
        @(negedge clk);
        chk("t6_core_yumi", 64'(bus.core_yumi_o), 64'd1);
        tick(); idle();
        @(negedge clk);
        chk("t6_core_data_v", 64'(bus.core_data_v_o), 64'd1);
        chk("t6_merged_data", 64'(bus.core_data_o), 64'hA122C344);
        tick();

        // Mixed traffic on a small address window; payload held until granted
        cg = 1; ng = 1;
        for (int i = 0; i < 80; i++) begin
            if (!bus.core_v_i || cg) begin
                bus.core_v_i = 1'($urandom_range(0, 1));
                bus.core_w_i = 1'($urandom_range(0, 1));
                bus.core_reserve_i = !bus.core_w_i && ($urandom_range(0, 2) == 0);
                bus.core_addr_i = AW'('h60 + $urandom_range(0, 3));
                bus.core_data_i = $urandom;
                bus.core_mask_i = MW'($urandom_range(0, 15));
            end
            if (!bus.net_v_i || ng) begin
                bus.net_v_i = ($urandom_range(0, 3) != 0);
                bus.net_w_i = 1'($urandom_range(0, 1));
                bus.net_addr_i = AW'('h60 + $urandom_range(0, 3));
                bus.net_data_i = $urandom;
                bus.net_mask_i = MW'($urandom_range(0, 15));
            end
            @(negedge clk);
            cg = bus.core_yumi_o;
            ng = bus.net_yumi_o;
            tick();
        end
        idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
